// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle control FSM and its ALU decoder.
package multicycle_controller_pkg;

    // Controller states (4-bit; encodings 11..15 are unused and recover to fetch)
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10
    } state_e;

    // Supported opcodes
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // FSM-to-decoder ALU request
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Datapath mux selects
    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_ALUOUT    = 1'b1;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RS1      = 2'b10;
    localparam logic [1:0] SRCB_RS2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] IMM_I         = 2'b00;
    localparam logic [1:0] IMM_S         = 2'b01;
    localparam logic [1:0] IMM_B         = 2'b10;
    localparam logic [1:0] IMM_J         = 2'b11;

    // Immediate format implied by the opcode; unknown opcodes fall back to I
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE: imm_src = IMM_S;
            OP_BEQ:   imm_src = IMM_B;
            OP_JAL:   imm_src = IMM_J;
            default:  imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU operation decode from the FSM request and instruction fields.
module mc_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_op5,
    output logic [2:0] o_alu_control
);

    // Map request and funct fields to an ALU operation
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // Only R-type (op[5] set) uses funct7[5] to select sub
                    3'b000:  o_alu_control = (i_funct7_5 & i_op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I-subset datapath with memory wait/timeout.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] Funct3,
    input  logic       Funct7_5,
    input  logic       zeroo,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic       bus_error
);

    localparam logic [7:0] WaitLimit = 8'(WAIT_LIMIT);

    state_e     r_state;
    logic [7:0] r_wait_cnt;
    logic       w_mem_state;
    logic       w_timeout;
    logic       w_hold;
    logic [1:0] w_alu_op;

    assign w_mem_state = (r_state == StFetch) || (r_state == StMemRead) ||
                         (r_state == StMemWrite);
    assign w_timeout   = w_mem_state && !mem_ready && (r_wait_cnt == WaitLimit);
    assign w_hold      = w_mem_state && !mem_ready && !w_timeout;

    // State register and wait counter; a timeout always falls back to fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StFetch;
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_hold ? r_wait_cnt + 8'd1 : 8'd0;
            case (r_state)
                StFetch:    if (mem_ready) r_state <= StDecode;
                StDecode: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: r_state <= StMemAdr;
                        OP_R:              r_state <= StExecuteR;
                        OP_I:              r_state <= StExecuteI;
                        OP_BEQ:            r_state <= StBeq;
                        OP_JAL:            r_state <= StJal;
                        default:           r_state <= StFetch;
                    endcase
                end
                StMemAdr:   r_state <= opcode[5] ? StMemWrite : StMemRead;
                StMemRead: begin
                    if (mem_ready)      r_state <= StMemWb;
                    else if (w_timeout) r_state <= StFetch;
                end
                StMemWrite: if (mem_ready || w_timeout) r_state <= StFetch;
                StExecuteR, StExecuteI, StJal: r_state <= StAluWb;
                StMemWb, StAluWb, StBeq:       r_state <= StFetch;
                default:    r_state <= StFetch;
            endcase
        end
    end

    // Per-state datapath controls
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = ADR_PC;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        w_alu_op   = ALUOP_ADD;
        RegWrite   = 1'b0;
        illegal_op = 1'b0;
        bus_error  = w_timeout;
        case (r_state)
            StFetch: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            StDecode: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE, OP_R, OP_I, OP_BEQ, OP_JAL: illegal_op = 1'b0;
                    default: illegal_op = 1'b1;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            StMemRead:  AdrSrc = ADR_ALUOUT;
            StMemWb: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            StMemWrite: begin
                AdrSrc   = ADR_ALUOUT;
                MemWrite = !w_timeout;
            end
            StExecuteR: begin
                ALUSrcA  = SRCA_RS1;
                w_alu_op = ALUOP_FUNCT;
            end
            StExecuteI: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
            end
            StAluWb:    RegWrite = 1'b1;
            StBeq: begin
                ALUSrcA  = SRCA_RS1;
                w_alu_op = ALUOP_SUB;
                PCWrite  = zeroo;
            end
            StJal: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            default: bus_error = 1'b0;
        endcase
    end

    assign ImmSrc = imm_src(opcode);

    mc_alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (Funct3),
        .i_funct7_5    (Funct7_5),
        .i_op5         (opcode[5]),
        .o_alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
// Output signature bits: [15] PCWrite [14] AdrSrc [13] MemWrite [12] IRWrite
// [11:10] ResultSrc [9:8] ALUSrcA [7:6] ALUSrcB [5:3] ALUControl
// [2] RegWrite [1] illegal_op [0] bus_error. Masks drop fields a state leaves undefined.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] Funct3;
    logic       Funct7_5;
    logic       zeroo;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op, bus_error;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_controller #(.WAIT_LIMIT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .Funct3     (Funct3),
        .Funct7_5   (Funct7_5),
        .zeroo      (zeroo),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .illegal_op (illegal_op),
        .bus_error  (bus_error)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sig();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, RegWrite, illegal_op, bus_error};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Power-on reset, then an asynchronous reset in the middle of a MEMREAD wait
    task automatic test_reset();
        logic [15:0] e [5] = '{16'h9880, 16'h0140, 16'h0240, 16'h4000, 16'h4000};
        logic [15:0] m [5] = '{16'hFFFF, 16'hB3FF, 16'hB3FF, 16'hFC07, 16'hFC07};
        logic        r [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (sig() !== 16'h0880) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %h want %h", i, sig(), 16'h0880);
            end
        end
        reset = 1'b0;
        opcode = 7'b0000011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = r[i];
            #1;
            n_checks++;
            if ((sig() & m[i]) !== (e[i] & m[i])) begin
                n_fail++;
                $display("FAIL reset_prep cycle %0d: got %h want %h", i, sig() & m[i], e[i] & m[i]);
            end
            if (i < 4) step();
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (sig() !== 16'h0880) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h", sig(), 16'h0880);
        end
        step();
        n_checks++;
        if ((sig() & 16'hB007) !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %h want %h", sig() & 16'hB007, 16'h0000);
        end
        reset = 1'b0;
    endtask

    // Fetch waits 16 cycles then aborts; then an unsupported opcode is decoded
    task automatic test_timeout_illegal();
        logic [15:0] exp;
        opcode = 7'b1111111;
        for (int i = 1; i <= 17; i++) begin
            mem_ready = 1'b0;
            #1;
            exp = (i == 16) ? 16'h0881 : 16'h0880;
            n_checks++;
            if (sig() !== exp) begin
                n_fail++;
                $display("FAIL fetch_timeout cycle %0d: got %h want %h", i, sig(), exp);
            end
            step();
        end
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (sig() !== 16'h9880) begin
            n_fail++;
            $display("FAIL illegal_fetch: got %h want %h", sig(), 16'h9880);
        end
        step();
        n_checks++;
        if ((sig() & 16'hB3FF) !== 16'h0142) begin
            n_fail++;
            $display("FAIL illegal_decode: got %h want %h", sig() & 16'hB3FF, 16'h0142);
        end
        step();
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (sig() !== 16'h0880) begin
            n_fail++;
            $display("FAIL illegal_return: got %h want %h", sig(), 16'h0880);
        end
        step();
    endtask

    // lw with memory always ready
    task automatic test_lw();
        logic [15:0] e [6] = '{16'h9880, 16'h0140, 16'h0240, 16'h4000, 16'h0404, 16'h0880};
        logic [15:0] m [6] = '{16'hFFFF, 16'hB3FF, 16'hB3FF, 16'hFC07, 16'hBC07, 16'hFFFF};
        logic        r [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 7'b0000011;
        #1;
        n_checks++;
        if (ImmSrc !== 2'b00) begin
            n_fail++;
            $display("FAIL lw_immsrc: got %b want %b", ImmSrc, 2'b00);
        end
        for (int i = 0; i < 6; i++) begin
            mem_ready = r[i];
            #1;
            n_checks++;
            if ((sig() & m[i]) !== (e[i] & m[i])) begin
                n_fail++;
                $display("FAIL lw cycle %0d: got %h want %h", i, sig() & m[i], e[i] & m[i]);
            end
            step();
        end
    endtask

    // sw with three wait cycles in MEMWRITE
    task automatic test_sw();
        logic [15:0] e [8] = '{16'h9880, 16'h0140, 16'h0240, 16'h6000,
                               16'h6000, 16'h6000, 16'h6000, 16'h0880};
        logic [15:0] m [8] = '{16'hFFFF, 16'hB3FF, 16'hB3FF, 16'hFC07,
                               16'hFC07, 16'hFC07, 16'hFC07, 16'hFFFF};
        logic        r [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = 7'b0100011;
        #1;
        n_checks++;
        if (ImmSrc !== 2'b01) begin
            n_fail++;
            $display("FAIL sw_immsrc: got %b want %b", ImmSrc, 2'b01);
        end
        for (int i = 0; i < 8; i++) begin
            mem_ready = r[i];
            #1;
            n_checks++;
            if ((sig() & m[i]) !== (e[i] & m[i])) begin
                n_fail++;
                $display("FAIL sw cycle %0d: got %h want %h", i, sig() & m[i], e[i] & m[i]);
            end
            step();
        end
    endtask

    // R-type sub, addi with funct7[5] set, R-type slt
    task automatic test_alu();
        logic [6:0]  ops [3] = '{7'b0110011, 7'b0010011, 7'b0110011};
        logic [2:0]  f3  [3] = '{3'b000, 3'b000, 3'b010};
        logic        f7  [3] = '{1'b1, 1'b1, 1'b0};
        logic [15:0] ex  [3] = '{16'h0208, 16'h0240, 16'h0228};
        logic [15:0] e, m;
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k];
            Funct3 = f3[k];
            Funct7_5 = f7[k];
            for (int c = 0; c < 4; c++) begin
                mem_ready = 1'b1;
                #1;
                e = (c == 0) ? 16'h9880 : (c == 1) ? 16'h0140 : (c == 2) ? ex[k] : 16'h0004;
                m = (c == 0) ? 16'hFFFF : (c == 3) ? 16'hBC07 : 16'hB3FF;
                n_checks++;
                if ((sig() & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL alu case %0d cycle %0d: got %h want %h", k, c, sig() & m, e & m);
                end
                step();
            end
        end
    endtask

    // beq taken then not taken
    task automatic test_beq();
        logic [15:0] e, m;
        opcode = 7'b1100011;
        #1;
        n_checks++;
        if (ImmSrc !== 2'b10) begin
            n_fail++;
            $display("FAIL beq_immsrc: got %b want %b", ImmSrc, 2'b10);
        end
        for (int k = 0; k < 2; k++) begin
            zeroo = (k == 0);
            for (int c = 0; c < 3; c++) begin
                mem_ready = 1'b1;
                #1;
                e = (c == 0) ? 16'h9880 : (c == 1) ? 16'h0140 : ((k == 0) ? 16'h8208 : 16'h0208);
                m = (c == 0) ? 16'hFFFF : (c == 1) ? 16'hB3FF : 16'hBFFF;
                n_checks++;
                if ((sig() & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL beq zero=%0d cycle %0d: got %h want %h", zeroo, c, sig() & m, e & m);
                end
                step();
            end
        end
    endtask

    // jal writes PC, then link writeback, back to fetch
    task automatic test_jal();
        logic [15:0] e [5] = '{16'h9880, 16'h0140, 16'h8180, 16'h0004, 16'h0880};
        logic [15:0] m [5] = '{16'hFFFF, 16'hB3FF, 16'hBFFF, 16'hBC07, 16'hFFFF};
        logic        r [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 7'b1101111;
        #1;
        n_checks++;
        if (ImmSrc !== 2'b11) begin
            n_fail++;
            $display("FAIL jal_immsrc: got %b want %b", ImmSrc, 2'b11);
        end
        for (int i = 0; i < 5; i++) begin
            mem_ready = r[i];
            #1;
            n_checks++;
            if ((sig() & m[i]) !== (e[i] & m[i])) begin
                n_fail++;
                $display("FAIL jal cycle %0d: got %h want %h", i, sig() & m[i], e[i] & m[i]);
            end
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        opcode = 7'b0000000;
        Funct3 = 3'b000;
        Funct7_5 = 1'b0;
        zeroo = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_timeout_illegal();
        test_lw();
        test_sw();
        test_alu();
        test_beq();
        test_jal();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
